// File: rtl/countdown_timer_8bit_pkg.sv
// rtl/countdown_timer_8bit_pkg.sv - shared types and constants for the 8-bit countdown timer
package countdown_timer_8bit_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } timer_state_e;

endpackage

// File: rtl/countdown_timer_8bit.sv
// rtl/countdown_timer_8bit.sv - loadable down-counter with load handshake, auto-reload and expiry pulse
module countdown_timer_8bit
  import countdown_timer_8bit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_value,
  input  logic             auto_reload,
  output logic             load_ready,
  input  logic             enable,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             expired,
  output logic [WIDTH-1:0] expire_cnt
);

  timer_state_e     state;
  logic [WIDTH-1:0] reload_reg;
  logic             mode;

  // Handshake flags come straight from the state register, never from load_valid.
  assign load_ready = (state == ST_IDLE);
  assign busy       = (state == ST_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      count      <= '0;
      reload_reg <= '0;
      mode       <= 1'b0;
      expired    <= 1'b0;
      expire_cnt <= '0;
    end else begin
      expired <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (load_valid) begin
            count      <= load_value;
            reload_reg <= load_value;
            mode       <= auto_reload;
            expire_cnt <= '0;
            state      <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Abort wins over a terminal event in the same cycle and freezes count.
          if (abort) begin
            state <= ST_IDLE;
          end else if (enable) begin
            if (count != '0) begin
              count <= count - 1'b1;
            end else begin
              expired <= 1'b1;
              if (expire_cnt != {WIDTH{1'b1}}) begin
                expire_cnt <= expire_cnt + 1'b1;
              end
              if (mode) begin
                count <= reload_reg;
              end else begin
                state <= ST_IDLE;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_timer_8bit.sv
// tb/tb_countdown_timer_8bit.sv - self-checking bench for countdown_timer_8bit
module tb_countdown_timer_8bit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_valid;
  logic [7:0] load_value;
  logic       auto_reload;
  logic       load_ready;
  logic       enable;
  logic       abort;
  logic [7:0] count;
  logic       busy;
  logic       expired;
  logic [7:0] expire_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: count is derived from enabled steps taken since the load.
  bit m_run;
  bit m_mode;
  bit m_exp;
  int m_n;
  int m_k;
  int m_idle_count;
  int m_expiries;

  countdown_timer_8bit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_value (load_value),
    .auto_reload(auto_reload),
    .load_ready (load_ready),
    .enable     (enable),
    .abort      (abort),
    .count      (count),
    .busy       (busy),
    .expired    (expired),
    .expire_cnt (expire_cnt)
  );

  always #5 clk = ~clk;

  function automatic int m_count();
    if (!m_run) return m_idle_count;
    if (m_mode) return m_n - (m_k % (m_n + 1));
    return m_n - m_k;
  endfunction

  task automatic model_reset();
    m_run = 0; m_mode = 0; m_exp = 0; m_n = 0; m_k = 0;
    m_idle_count = 0; m_expiries = 0;
  endtask

  task automatic model_step(input bit lv, input int val, input bit ar, input bit en, input bit ab);
    m_exp = 0;
    if (!m_run) begin
      if (lv) begin
        m_run = 1; m_n = val; m_mode = ar; m_k = 0; m_expiries = 0;
      end
    end else if (ab) begin
      m_idle_count = m_count();
      m_run = 0;
    end else if (en) begin
      m_k++;
      if (m_k % (m_n + 1) == 0) begin
        m_exp = 1;
        m_expiries++;
        if (!m_mode) begin
          m_run = 0;
          m_idle_count = 0;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("count", 32'(count), m_count());
    chk("busy", 32'(busy), 32'(m_run));
    chk("load_ready", 32'(load_ready), 32'(!m_run));
    chk("expired", 32'(expired), 32'(m_exp));
    chk("expire_cnt", 32'(expire_cnt), (m_expiries > 255) ? 255 : m_expiries);
  endtask

  // Called at a falling edge: drive, take the rising edge, compare at the next falling edge.
  task automatic cycle(input bit lv, input int val, input bit ar, input bit en, input bit ab);
    load_valid  = lv;
    load_value  = val[7:0];
    auto_reload = ar;
    enable      = en;
    abort       = ab;
    @(posedge clk);
    model_step(lv, val, ar, en, ab);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int pulses;
    rst_n = 1'b0; load_valid = 0; load_value = 0; auto_reload = 0; enable = 0; abort = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // One-shot load of 3 with enable held high on the load cycle too.
    cycle(1, 3, 0, 1, 0);
    chk("t1_load_count", 32'(count), 3);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 1, 0);
      if (i < 3) chk("t1_count_step", 32'(count), 2 - i);
    end
    chk("t1_expired", 32'(expired), 1);
    chk("t1_idle", 32'(busy), 0);
    chk("t1_expire_cnt", 32'(expire_cnt), 1);
    chk("t1_ready", 32'(load_ready), 1);
    cycle(0, 0, 0, 1, 0);
    chk("t1_pulse_width", 32'(expired), 0);

    // Auto-reload of 2 for nine enabled cycles.
    cycle(1, 2, 1, 0, 0);
    pulses = 0;
    for (int i = 0; i < 9; i++) begin
      cycle(0, 0, 0, 1, 0);
      if (expired) pulses++;
    end
    chk("t2_pulses", 32'(pulses), 3);
    chk("t2_busy", 32'(busy), 1);
    chk("t2_expire_cnt", 32'(expire_cnt), 3);
    cycle(0, 0, 0, 0, 1);

    // Enable gaps stall the count.
    cycle(1, 5, 0, 0, 0);
    cycle(0, 0, 0, 1, 0); chk("t3_c1", 32'(count), 4);
    cycle(0, 0, 0, 0, 0); chk("t3_c2", 32'(count), 4);
    cycle(0, 0, 0, 1, 0); chk("t3_c3", 32'(count), 3);
    cycle(0, 0, 0, 0, 0); chk("t3_c4", 32'(count), 3);
    cycle(0, 0, 0, 0, 1);

    // Zero loads, one-shot then auto-reload.
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0);
    chk("t4_zero_expired", 32'(expired), 1);
    chk("t4_zero_idle", 32'(busy), 0);
    cycle(1, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0, 1, 0);
      chk("t4_zero_auto_pulse", 32'(expired), 1);
    end
    cycle(0, 0, 0, 0, 1);

    // Abort beats terminal; loads during RUN are ignored.
    cycle(1, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 1);
    chk("t5_no_pulse", 32'(expired), 0);
    chk("t5_idle", 32'(busy), 0);
    chk("t5_count", 32'(count), 0);
    cycle(1, 7, 0, 0, 0);
    cycle(1, 99, 0, 0, 0);
    chk("t5_no_reaccept", 32'(count), 7);
    cycle(1, 99, 1, 1, 0);
    chk("t5_run_decrement", 32'(count), 6);
    cycle(0, 0, 0, 0, 1);

    // expire_cnt saturation via zero-length auto-reload.
    cycle(1, 0, 1, 0, 0);
    repeat (260) cycle(0, 0, 0, 1, 0);
    chk("sat_expire_cnt", 32'(expire_cnt), 255);
    cycle(0, 0, 0, 0, 1);

    // Asynchronous reset in the middle of a long auto-reload run.
    cycle(1, 200, 1, 0, 0);
    repeat (37) cycle(0, 0, 0, 1, 0);
    rst_n = 1'b0;
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_expired", 32'(expired), 0);
    chk("rst_expire_cnt", 32'(expire_cnt), 0);
    chk("rst_ready", 32'(load_ready), 1);
    model_reset();
    @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // Randomized traffic against the reference.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom % 4) == 0,
            ($urandom % 2) ? int'($urandom % 6) : int'($urandom % 256),
            1'($urandom % 2),
            ($urandom % 4) != 0,
            ($urandom % 16) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
